// File: rtl/apple_rand_gen.sv
// apple_rand_gen: LFSR-driven apple candidate responder for the snake board.
// Optional entropy mixing of apple-eaten events: define APPLE_RAND_MIX_EN.
module apple_rand_gen #(
  parameter int          LFSR_W    = 16,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MAX_TRIES = 8
) (
  input  logic       system_clk,
  input  logic       nreset,
  input  logic       enable,
  input  logic       good_collision,
  input  logic [7:0] seed_mix,
  input  logic [3:0] XMAX,
  input  logic [3:0] XMIN,
  input  logic [3:0] YMAX,
  input  logic [3:0] YMIN,
  output logic [7:0] apple_possible,
  output logic       possible_valid,
  output logic       fallback
);

  localparam logic [LFSR_W-1:0] TAPS = 16'hB400;
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam logic [TW-1:0] LAST = TW'(MAX_TRIES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [TW-1:0]     tries_q, tries_d;
  logic [7:0]        apple_q, apple_d;
  logic              valid_q, valid_d;
  logic              fb_q, fb_d;

  logic [LFSR_W-1:0] nxt;
  logic [LFSR_W-1:0] base;
  logic [LFSR_W-1:0] raw;
  logic [7:0]        cand;
  logic [3:0]        fb_x;
  logic [3:0]        fb_y;
  logic              legal;
  logic              service;

  always_comb begin
    nxt  = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
    cand = nxt[7:0];
    fb_x = XMIN + 4'd1;
    fb_y = YMIN + 4'd1;
    legal = (cand[3:0] > XMIN) && (cand[3:0] < XMAX)
         && (cand[7:4] > YMIN) && (cand[7:4] < YMAX);
    service = enable && ((state_q == IDLE) || (state_q == SEARCH));
    base = service ? nxt : lfsr_q;
  end

`ifdef APPLE_RAND_MIX_EN
  always_comb begin
    raw = base;
    if (good_collision) begin
      raw = base ^ {{(LFSR_W-8){1'b0}}, seed_mix};
    end
  end
`else
  logic unused_mix;
  assign unused_mix = ^{good_collision, seed_mix};
  assign raw = base;
`endif

  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    apple_d = apple_q;
    valid_d = 1'b0;
    fb_d    = 1'b0;
    // A zero LFSR would stick forever, so reload the seed instead.
    lfsr_d  = (raw == '0) ? SEED : raw;
    unique case (state_q)
      IDLE, SEARCH: begin
        if (service) begin
          if (legal) begin
            apple_d = cand;
            valid_d = 1'b1;
            tries_d = '0;
            state_d = DONE;
          end else if (tries_q == LAST) begin
            apple_d = {fb_y, fb_x};
            valid_d = 1'b1;
            fb_d    = 1'b1;
            tries_d = '0;
            state_d = DONE;
          end else begin
            tries_d = tries_q + 1'b1;
            state_d = SEARCH;
          end
        end else begin
          tries_d = '0;
          state_d = IDLE;
        end
      end
      DONE: begin
        if (!enable) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        tries_d = '0;
      end
    endcase
  end

  always_ff @(posedge system_clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      tries_q <= '0;
      apple_q <= 8'h00;
      valid_q <= 1'b0;
      fb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      tries_q <= tries_d;
      apple_q <= apple_d;
      valid_q <= valid_d;
      fb_q    <= fb_d;
    end
  end

  assign apple_possible = apple_q;
  assign possible_valid = valid_q;
  assign fallback       = fb_q;

endmodule

// File: tb/tb_apple_rand_gen.sv
// Directed bench for apple_rand_gen.
// Expected LFSR values come from hand-worked steps and a tiny Galois model.
module tb_apple_rand_gen;

  logic       clk;
  logic       nreset;
  logic       enable;
  logic       good_collision;
  logic [7:0] seed_mix;
  logic [3:0] xmax, xmin, ymax, ymin;
  logic [7:0] apple_possible;
  logic       possible_valid;
  logic       fallback;

  int n_cmp;
  int n_bad;
  logic [15:0] m_lfsr;

  apple_rand_gen dut (
    .system_clk     (clk),
    .nreset         (nreset),
    .enable         (enable),
    .good_collision (good_collision),
    .seed_mix       (seed_mix),
    .XMAX           (xmax),
    .XMIN           (xmin),
    .YMAX           (ymax),
    .YMIN           (ymin),
    .apple_possible (apple_possible),
    .possible_valid (possible_valid),
    .fallback       (fallback)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] step(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    nreset = 1'b0;
    enable = 1'b0;
    good_collision = 1'b0;
    seed_mix = 8'h00;
    xmin = 4'd0; xmax = 4'd15;
    ymin = 4'd0; ymax = 4'd15;
    #12;
    n_cmp++;
    if ({apple_possible, possible_valid, fallback} !== 10'h000) begin
      n_bad++;
      $display("FAIL reset_out: got %h/%b/%b want 00/0/0",
               apple_possible, possible_valid, fallback);
    end
    n_cmp++;
    if (dut.lfsr_q !== 16'hACE1) begin
      n_bad++;
      $display("FAIL reset_lfsr: got %h want ace1", dut.lfsr_q);
    end
    nreset = 1'b1;
    tick();
    m_lfsr = 16'hACE1;
  endtask

  task automatic test_accept;
    enable = 1'b1;
    tick();
    n_cmp++;
    if (possible_valid !== 1'b0 || dut.lfsr_q !== 16'hE270) begin
      n_bad++;
      $display("FAIL t1_edge1: got v=%b lfsr=%h want v=0 lfsr=e270",
               possible_valid, dut.lfsr_q);
    end
    tick();
    n_cmp++;
    if (apple_possible !== 8'h38 || possible_valid !== 1'b1
        || fallback !== 1'b0) begin
      n_bad++;
      $display("FAIL t1_accept: got %h/%b/%b want 38/1/0",
               apple_possible, possible_valid, fallback);
    end
    n_cmp++;
    if (dut.state_q !== 2'd2 || dut.lfsr_q !== 16'h7138) begin
      n_bad++;
      $display("FAIL t1_state: got st=%0d lfsr=%h want st=2 lfsr=7138",
               dut.state_q, dut.lfsr_q);
    end
    m_lfsr = 16'h7138;
    tick();
    n_cmp++;
    if (possible_valid !== 1'b0 || apple_possible !== 8'h38) begin
      n_bad++;
      $display("FAIL t1_pulse: got v=%b ap=%h want v=0 ap=38",
               possible_valid, apple_possible);
    end
  endtask

  task automatic test_hold;
    int extra;
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (possible_valid !== 1'b0) extra++;
      if (dut.lfsr_q !== m_lfsr) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_bad++;
      $display("FAIL t3_hold: got %0d bad cycles want 0", extra);
    end
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    m_lfsr = step(m_lfsr);
    n_cmp++;
    if (apple_possible !== 8'h9C || possible_valid !== 1'b1
        || dut.lfsr_q !== 16'h389C) begin
      n_bad++;
      $display("FAIL t3_rerequest: got %h/%b lfsr=%h want 9c/1 lfsr=389c",
               apple_possible, possible_valid, dut.lfsr_q);
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_fallback;
    int early;
    early = 0;
    xmin = 4'd7; xmax = 4'd8;
    ymin = 4'd2; ymax = 4'd15;
    enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      m_lfsr = step(m_lfsr);
      if (possible_valid !== 1'b0 || fallback !== 1'b0) early++;
    end
    n_cmp++;
    if (early != 0) begin
      n_bad++;
      $display("FAIL t2_early: got %0d early pulses want 0", early);
    end
    tick();
    m_lfsr = step(m_lfsr);
    n_cmp++;
    if (apple_possible !== 8'h38 || possible_valid !== 1'b1
        || fallback !== 1'b1) begin
      n_bad++;
      $display("FAIL t2_fallback: got %h/%b/%b want 38/1/1",
               apple_possible, possible_valid, fallback);
    end
    n_cmp++;
    if (dut.lfsr_q !== m_lfsr) begin
      n_bad++;
      $display("FAIL t2_lfsr: got %h want %h", dut.lfsr_q, m_lfsr);
    end
    tick();
    n_cmp++;
    if (possible_valid !== 1'b0 || fallback !== 1'b0) begin
      n_bad++;
      $display("FAIL t2_pulse: got %b/%b want 0/0",
               possible_valid, fallback);
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_abort;
    int seen;
    int first;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      m_lfsr = step(m_lfsr);
    end
    enable = 1'b0;
    tick();
    n_cmp++;
    if (possible_valid !== 1'b0 || dut.state_q !== 2'd0
        || dut.tries_q !== '0) begin
      n_bad++;
      $display("FAIL t4_abort: got v=%b st=%0d tries=%0d want 0/0/0",
               possible_valid, dut.state_q, dut.tries_q);
    end
    n_cmp++;
    if (dut.lfsr_q !== m_lfsr) begin
      n_bad++;
      $display("FAIL t4_lfsr: got %h want %h", dut.lfsr_q, m_lfsr);
    end
    seen = 0;
    first = 0;
    enable = 1'b1;
    for (int i = 1; i <= 10 && seen == 0; i++) begin
      tick();
      if (possible_valid === 1'b1) begin
        seen = 1;
        first = i;
      end
    end
    n_cmp++;
    if (first != 8 || fallback !== 1'b1) begin
      n_bad++;
      $display("FAIL t4_retry: got edge=%0d fb=%b want edge=8 fb=1",
               first, fallback);
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_async_reset;
    enable = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (dut.state_q !== 2'd1) begin
      n_bad++;
      $display("FAIL t5_search: got st=%0d want 1", dut.state_q);
    end
    #2;
    nreset = 1'b0;
    #1;
    n_cmp++;
    if (apple_possible !== 8'h00 || possible_valid !== 1'b0
        || fallback !== 1'b0 || dut.lfsr_q !== 16'hACE1) begin
      n_bad++;
      $display("FAIL t5_async: got %h/%b/%b lfsr=%h want 00/0/0 ace1",
               apple_possible, possible_valid, fallback, dut.lfsr_q);
    end
    xmin = 4'd0; xmax = 4'd15;
    ymin = 4'd0; ymax = 4'd15;
    #1;
    nreset = 1'b1;
    tick();
    n_cmp++;
    if (possible_valid !== 1'b0 || dut.lfsr_q !== 16'hE270) begin
      n_bad++;
      $display("FAIL t5_edge1: got v=%b lfsr=%h want v=0 lfsr=e270",
               possible_valid, dut.lfsr_q);
    end
    tick();
    n_cmp++;
    if (apple_possible !== 8'h38 || possible_valid !== 1'b1
        || fallback !== 1'b0) begin
      n_bad++;
      $display("FAIL t5_repeat: got %h/%b/%b want 38/1/0",
               apple_possible, possible_valid, fallback);
    end
    enable = 1'b0;
    tick();
  endtask

`ifdef APPLE_RAND_MIX_EN
  task automatic test_mix;
    nreset = 1'b0;
    #3;
    nreset = 1'b1;
    enable = 1'b0;
    good_collision = 1'b1;
    seed_mix = 8'h01;
    tick();
    n_cmp++;
    if (dut.lfsr_q !== 16'hACE0) begin
      n_bad++;
      $display("FAIL t6_mix01: got %h want ace0", dut.lfsr_q);
    end
    seed_mix = 8'hE0;
    tick();
    n_cmp++;
    if (dut.lfsr_q !== 16'hAC00) begin
      n_bad++;
      $display("FAIL t6_mixe0: got %h want ac00", dut.lfsr_q);
    end
    good_collision = 1'b0;
    tick();
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_lfsr = 16'h0000;
    test_reset();
    test_accept();
    test_hold();
    test_fallback();
    test_abort();
    test_async_reset();
`ifdef APPLE_RAND_MIX_EN
    test_mix();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
